control_unit: RTL

Microcoded sequencer for the 8-bit bus CPU. Holds the T-state counter and drives every load/drive strobe consumed by the bus registers, PC, MAR, RAM, ALU and output register, from the instruction register's opcode and the ALU flags. It sits directly upstream of every bus register: it produces their `read_from_bus` / `write_to_bus` strobes and guarantees at most one bus driver per cycle.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/microcode_rom.sv | 82 ++++++++
 rtl/control_unit.sv | 66 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit bus CPU control path.
// Includes the opcode set, the control-word layout and instruction lengths.
package cpu_pkg;

   typedef enum logic [3:0] {
      OpNop = 4'h0,
      OpLda = 4'h1,
      OpAdd = 4'h2,
      OpSub = 4'h3,
      OpSta = 4'h4,
      OpLdi = 4'h5,
      OpJmp = 4'h6,
      OpJc  = 4'h7,
      OpJz  = 4'h8,
      OpOut = 4'hE,
      OpHlt = 4'hF
   } opcode_t;

   // First field is the MSB of the packed word.
   typedef struct packed {
      logic pc_inc;
      logic pc_out;
      logic pc_jump;
      logic mar_in;
      logic ram_in;
      logic ram_out;
      logic ir_in;
      logic ir_out;
      logic a_in;
      logic a_out;
      logic b_in;
      logic alu_out;
      logic alu_sub;
      logic flags_in;
      logic out_in;
      logic halt;
   } ctrl_word_t;

   localparam int unsigned T0 = 0;
   localparam int unsigned T1 = 1;
   localparam int unsigned T2 = 2;
   localparam int unsigned T3 = 3;
   localparam int unsigned T4 = 4;

   localparam int unsigned LenNop   = 2;
   localparam int unsigned LenMem   = 4;
   localparam int unsigned LenAlu   = 5;
   localparam int unsigned LenShort = 3;

   function automatic int unsigned instr_len(input logic [3:0] op);
      case (opcode_t'(op))
         OpLda, OpSta:                      instr_len = LenMem;
         OpAdd, OpSub:                      instr_len = LenAlu;
         OpLdi, OpJmp, OpJc, OpJz, OpOut,
         OpHlt:                             instr_len = LenShort;
         default:                           instr_len = LenNop;
      endcase
   endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (opcode, T-state, flags) to a control word.
// Also reports whether the current T-state is the instruction's last.
module microcode_rom
   import cpu_pkg::*;
#(
   parameter int unsigned STEP_W = 3
) (
   input  logic [3:0]        opcode,
   input  logic [STEP_W-1:0] step,
   input  logic              carry_flag,
   input  logic              zero_flag,
   output ctrl_word_t        ctrl,
   output logic              last_step
);

   logic [31:0] t;

   always_comb begin
      ctrl      = '0;
      t         = 32'(step);
      last_step = (t == instr_len(opcode) - 1);

      if (t == T0) begin
         ctrl.pc_out = 1'b1;
         ctrl.mar_in = 1'b1;
      end else if (t == T1) begin
         ctrl.ram_out = 1'b1;
         ctrl.ir_in   = 1'b1;
         ctrl.pc_inc  = 1'b1;
      end else begin
         // Execute phase: opcode is valid from T2 onward.
         case (opcode_t'(opcode))
            OpLda, OpAdd, OpSub, OpSta: begin
               if (t == T2) begin
                  ctrl.ir_out = 1'b1;
                  ctrl.mar_in = 1'b1;
               end else if (t == T3) begin
                  if (opcode_t'(opcode) == OpSta) begin
                     ctrl.a_out  = 1'b1;
                     ctrl.ram_in = 1'b1;
                  end else begin
                     ctrl.ram_out = 1'b1;
                     ctrl.a_in    = (opcode_t'(opcode) == OpLda);
                     ctrl.b_in    = (opcode_t'(opcode) != OpLda);
                  end
               end else if (t == T4 && opcode_t'(opcode) != OpLda
                            && opcode_t'(opcode) != OpSta) begin
                  ctrl.alu_out  = 1'b1;
                  ctrl.a_in     = 1'b1;
                  ctrl.flags_in = 1'b1;
                  ctrl.alu_sub  = (opcode_t'(opcode) == OpSub);
               end
            end
            OpLdi: if (t == T2) begin
               ctrl.ir_out = 1'b1;
               ctrl.a_in   = 1'b1;
            end
            OpJmp: if (t == T2) begin
               ctrl.ir_out  = 1'b1;
               ctrl.pc_jump = 1'b1;
            end
            OpJc: if (t == T2) begin
               ctrl.ir_out  = 1'b1;
               ctrl.pc_jump = carry_flag;
            end
            OpJz: if (t == T2) begin
               ctrl.ir_out  = 1'b1;
               ctrl.pc_jump = zero_flag;
            end
            OpOut: if (t == T2) begin
               ctrl.a_out  = 1'b1;
               ctrl.out_in = 1'b1;
            end
            OpHlt: if (t == T2) begin
               ctrl.halt = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// T-state sequencer for the 8-bit bus CPU: step counter, sticky halt,
// reset forcing and halt gating around the microcode ROM.
module control_unit
   import cpu_pkg::*;
#(
   parameter int unsigned STEP_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        opcode,
   input  logic              carry_flag,
   input  logic              zero_flag,
   output ctrl_word_t        ctrl,
   output logic [STEP_W-1:0] step,
   output logic              halted
);

   logic [STEP_W-1:0] step_q, step_d;
   logic              halted_q, halted_d;
   ctrl_word_t        rom_ctrl;
   logic              rom_last;

   microcode_rom #(
      .STEP_W(STEP_W)
   ) u_rom (
      .opcode    (opcode),
      .step      (step_q),
      .carry_flag(carry_flag),
      .zero_flag (zero_flag),
      .ctrl      (rom_ctrl),
      .last_step (rom_last)
   );

   always_comb begin
      step_d   = step_q + STEP_W'(1);
      halted_d = halted_q | (rom_ctrl.halt & ~halted_q);
      if (halted_q || rom_last) begin
         step_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   // Reset wins over halt so no strobe escapes while rst_n is low.
   always_comb begin
      ctrl = rom_ctrl;
      if (!rst_n) begin
         ctrl = '0;
      end else if (halted_q) begin
         ctrl      = '0;
         ctrl.halt = 1'b1;
      end
   end

   assign step   = step_q;
   assign halted = halted_q;

endmodule
